// File: rtl/alu_md_unit.sv
// rtl/alu_md_unit.sv - execute-stage ALU with registered results and optional iterative multiply/divide
// Optional feature macro: ALU_MULDIV_EN
//   defined   : ops 9-12 (MUL, MULH, DIV, REM) run one bit per cycle, WIDTH+1 cycle latency
//   undefined : no multiply/divide datapath; ops 9-12 act as NOP (result 0, latency 1), in_ready tied to 1
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of the in-flight op; drops an op offered in the same cycle
//   in_valid   operands/op valid          in_ready   unit can accept this cycle
//   operand_a  source A                   operand_b  source B / shift amount (low SHW bits)
//   alu_op     operation select (0 ADD .. 8 LUI, 9 MUL, 10 MULH, 11 DIV, 12 REM, 15 NOP)
//   out_valid  one-cycle result pulse     alu_result registered result
//   zero       compare flag of alu_result: 00 zero, 01 positive, 10 negative
module alu_md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic [1:0]       zero
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       zero_q, zero_d;

    logic             ready;
    logic             accept;
    logic             start_md;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;

    function automatic logic [1:0] cmp_flag(input logic [WIDTH-1:0] v);
        if (v == '0) begin
            return 2'b00;
        end else if (v[WIDTH-1]) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

    assign shamt  = operand_b[SHW-1:0];
    // ready is low throughout CALC, so accept can only fire in IDLE/DONE
    assign accept = in_valid && ready && !flush;

    always_comb begin : single_cycle_ops
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = operand_a + operand_b;
            4'd1:    alu_res = operand_a - operand_b;
            4'd2:    alu_res = operand_a & operand_b;
            4'd3:    alu_res = operand_a | operand_b;
            4'd4:    alu_res = operand_a ^ operand_b;
            4'd5:    alu_res = operand_a << shamt;
            4'd6:    alu_res = operand_a >> shamt;
            4'd7:    alu_res = $signed(operand_a) >>> shamt;
            4'd8:    alu_res = operand_b;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic             in_ready_q, in_ready_d;
    logic [SHW:0]     count_q, count_d;
    // hi/lo: product {hi,lo} for multiply, {remainder, dividend/quotient} for divide
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [1:0]       md_op_q, md_op_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;

    logic             is_md;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] hi_nx, lo_nx, md_res;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign ready    = in_ready_q;
    assign is_md    = (alu_op >= 4'd9) && (alu_op <= 4'd12);
    assign start_md = accept && is_md;
    assign a_neg    = operand_a[WIDTH-1];
    assign b_neg    = operand_b[WIDTH-1];
    // Most-negative maps onto itself, which reads correctly as the unsigned magnitude
    assign abs_a    = a_neg ? -operand_a : operand_a;
    assign abs_b    = b_neg ? -operand_b : operand_b;

    always_comb begin : md_step
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, mcand_q};
        div_ge   = (div_sh >= {1'b0, mcand_q});
        if (md_op_q[1]) begin
            // restoring divide: quotient bits shift into lo from the right
            hi_nx = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            lo_nx = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            // shift-add multiply: consume multiplier LSB, shift product right
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod   = {hi_nx, lo_nx};
        prod_s = neg_q ? -prod : prod;
        case (md_op_q)
            2'd0:    md_res = prod_s[WIDTH-1:0];
            2'd1:    md_res = prod_s[2*WIDTH-1:WIDTH];
            2'd2:    md_res = neg_q ? -lo_nx : lo_nx;
            default: md_res = neg_rem_q ? -hi_nx : hi_nx;
        endcase
    end
`else
    assign ready    = 1'b1;
    assign start_md = 1'b0;
`endif

    always_comb begin : fsm_next
        state_d     = state_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
`ifdef ALU_MULDIV_EN
        in_ready_d  = in_ready_q;
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mcand_d     = mcand_q;
        md_op_d     = md_op_q;
        neg_d       = neg_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
`ifdef ALU_MULDIV_EN
            S_CALC: begin
                if (flush) begin
                    state_d    = S_IDLE;
                    in_ready_d = 1'b1;
                    count_d    = '0;
                end else begin
                    hi_d    = hi_nx;
                    lo_d    = lo_nx;
                    count_d = count_q - (SHW+1)'(1);
                    if (count_q == (SHW+1)'(1)) begin
                        state_d     = S_DONE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b1;
                        result_d    = md_res;
                        zero_d      = cmp_flag(md_res);
                    end
                end
            end
`endif
            default: begin
                // IDLE and DONE behave identically; DONE only marks the completion cycle
                state_d = S_IDLE;
`ifdef ALU_MULDIV_EN
                in_ready_d = 1'b1;
                if (start_md) begin
                    state_d    = S_CALC;
                    in_ready_d = 1'b0;
                    count_d    = (SHW+1)'(WIDTH);
                    hi_d       = '0;
                    lo_d       = abs_a;
                    mcand_d    = abs_b;
                    // 9,10,11,12 -> 0,1,2,3
                    md_op_d    = alu_op[1:0] + 2'd3;
                    // a zero divisor keeps the all-ones magnitude un-negated
                    neg_d      = (a_neg ^ b_neg) && (operand_b != '0);
                    neg_rem_d  = a_neg;
                end
`endif
                if (accept && !start_md) begin
                    result_d    = alu_res;
                    zero_d      = cmp_flag(alu_res);
                    out_valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 2'b00;
`ifdef ALU_MULDIV_EN
            in_ready_q  <= 1'b1;
            count_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mcand_q     <= '0;
            md_op_q     <= 2'd0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
`ifdef ALU_MULDIV_EN
            in_ready_q  <= in_ready_d;
            count_q     <= count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mcand_q     <= mcand_d;
            md_op_q     <= md_op_d;
            neg_q       <= neg_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign in_ready   = ready;
    assign out_valid  = out_valid_q;
    assign alu_result = result_q;
    assign zero       = zero_q;

endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
- Parametrised next-generation execute-stage ALU for the five-stage pipeline.
- Covers all existing single-cycle ops (add/sub/logic/shift/LUI pass-through) with registered results.
- Adds iterative multi-cycle multiply/divide/remainder behind a valid/ready handshake.
- EX-stage control stalls the pipeline on in_ready low; the result and the 2-bit compare flag go to EX/MEM on out_valid.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64; SHW = clog2(WIDTH) is derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the in-flight op (branch mispredict)
- in_valid  in  1  operands/op valid
- in_ready  out  1  unit can accept this cycle
- operand_a  in  WIDTH  source A
- operand_b  in  WIDTH  source B / shift amount (low SHW bits)
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 LUI (result=B), 9 MUL (low half), 10 MULH (signed high half), 11 DIV (signed), 12 REM (signed), 13-14 reserved, 15 NOP (result 0)
- out_valid  out  1  one-cycle pulse, result valid
- alu_result  out  WIDTH  registered result
- zero  out  2  compare flag of alu_result: 2'b00 equal (zero), 2'b01 greater (MSB 0, nonzero), 2'b10 less (MSB 1)

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, in_ready=1, out_valid=0, alu_result=0, zero=2'b00.
  - All iteration registers are cleared.
  - An op in flight when reset asserts is discarded silently.
- Accept: in_valid && in_ready at a rising edge. Operands and op are captured at that edge.
- FSM states: IDLE, CALC, DONE.
- IDLE, single-cycle op accepted (0-8, 15, reserved):
  - alu_result and zero update at the accept edge.
  - out_valid=1 for the following cycle. Latency 1.
  - Stay IDLE; in_ready stays 1, so back-to-back issue runs at 1 op/cycle.
- IDLE, op 9-12 accepted:
  - Go to CALC; in_ready=0; load iteration count = WIDTH.
  - Multiply: shift-add over unsigned magnitudes; negate at end for MULH sign.
  - Divide: restoring, over absolute values.
  - One bit per cycle.
- CALC -> DONE after WIDTH iteration edges.
  - At that edge: alu_result/zero written, out_valid=1 for one cycle, in_ready=1.
  - Total latency WIDTH+1 cycles from the accept edge.
- DONE accepts a new op in the same cycle (treated as IDLE). DONE -> IDLE (or CALC) next edge.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Shifts use operand_b[SHW-1:0] only; SRA replicates MSB.
  - MUL returns the low WIDTH bits of the product. The sign of operands is irrelevant for the low half.
  - MULH returns the signed x signed high WIDTH bits.
- Division boundaries:
  - DIV by zero: quotient = all ones.
  - REM by zero: result = operand_a.
  - DIV of most-negative by -1: result = most-negative.
  - REM of most-negative by -1: result = 0.
  - Remainder sign follows the dividend.
- zero always reflects the registered alu_result. It holds with alu_result between ops.
- alu_result/zero hold their last value when out_valid=0. NOP produces result 0 and zero=2'b00.
- flush:
  - In CALC, the op is aborted; go to IDLE next edge with no out_valid, and alu_result unchanged.
  - In IDLE/DONE, an op accepted in the same cycle as flush is dropped.
  - A pending out_valid pulse in that cycle still completes.
  - flush has priority over accept.
- in_valid while in_ready=0 is ignored; the upstream stage must hold it.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: ops 9-12 behave as above.
- Undefined:
  - No multiply/divide datapath is synthesised.
  - Ops 9-12 behave as NOP: result 0, latency 1.
  - CALC is unreachable and in_ready is tied to 1.

Test Plan:
- Reset mid-CALC: DIV 100/7 accepted, rst_n low 5 cycles later -> out_valid never pulses, alu_result=0, in_ready=1 immediately.
- Back-to-back single-cycle ops: ADD 0x7FFFFFFF+1, then SUB 5-5, then SRA 0x80000000>>4 on consecutive cycles -> results 0x80000000/zero=10, 0/zero=00, 0xF8000000/zero=10, each one cycle after accept.
- MUL/MULH: MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULH of the same -> 0x00000000. out_valid exactly 33 cycles after accept, with in_ready low in between.
- Divide boundaries:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIV 9/0 -> 0xFFFFFFFF; REM 9/0 -> 9.
  - DIV 0x80000000/-1 -> 0x80000000.
- Flush: DIV accepted, flush asserted after 10 cycles -> no out_valid, alu_result keeps the prior value, in_ready=1 next cycle; an ADD accepted in the flush cycle is dropped.
- Macro off (ALU_MULDIV_EN undefined): MUL 3*4 -> result 0, out_valid one cycle after accept, in_ready never deasserts.
